// File: rtl/rr_mux_arbiter_if.sv
// Request/grant bus between N requesters and the arbiter, plus the muxed output stream.
// master: requester/consumer side (drives req, din, req_mask, out_ready).
// slave : arbiter side (drives gnt, out_valid, out_data, out_sel, busy).
interface rr_mux_arbiter_if #(
  parameter int NREQ = 8,
  parameter int DW   = 4,
  parameter int SELW = 3
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] din;
  logic [NREQ-1:0]    req_mask;
  logic [NREQ-1:0]    gnt;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [SELW-1:0]    out_sel;
  logic               busy;

  modport master (
    output req, din, req_mask, out_ready,
    input  gnt, out_valid, out_data, out_sel, busy
  );

  modport slave (
    input  req, din, req_mask, out_ready,
    output gnt, out_valid, out_data, out_sel, busy
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one NREQ:1 x DW mux; registers the winner's word into a 1-entry output stage.
// Latency: gnt (combinational) to out_valid is 1 cycle; sustains 1 word/cycle with out_ready held high.
// Backpressure: while the output word is unaccepted, gnt stays 0 and out_data/out_sel hold.
// Ports: clk, rst_n (async, active-low); io = slave side of rr_mux_arbiter_if
//   (req/din/req_mask/out_ready in; gnt/out_valid/out_data/out_sel/busy out).
module rr_mux_arbiter #(
  parameter int NREQ = 8,
  parameter int DW   = 4,
  parameter int SELW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_mux_arbiter_if.slave io
);

  typedef enum logic {IDLE, FULL} state_t;

  state_t          state;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] sel_q;
  logic [DW-1:0]   data_q;
  logic            vld_q;

  logic [NREQ-1:0] elig;
  logic [SELW-1:0] win;
  logic [SELW-1:0] idx;
  logic            take;

  assign elig = io.req & io.req_mask;

  // Scan offsets from farthest to nearest so the index closest to ptr
  // (in wrap order) is the last to write win and therefore wins.
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + SELW'(k);
      if (elig[idx]) win = idx;
    end
  end

  // rst_n gates take so no grant leaks out while reset is held.
  assign take = rst_n & ((state == IDLE) | io.out_ready) & (|elig);

  assign io.gnt       = take ? (NREQ'(1) << win) : '0;
  assign io.out_valid = vld_q;
  assign io.busy      = vld_q;
  assign io.out_data  = data_q;
  assign io.out_sel   = sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      vld_q  <= 1'b0;
      data_q <= '0;
      sel_q  <= '0;
      ptr    <= '0;
    end else if (take) begin
      // Covers IDLE capture and the back-to-back FULL reload alike.
      state  <= FULL;
      vld_q  <= 1'b1;
      data_q <= io.din[win*DW +: DW];
      sel_q  <= win;
      ptr    <= win + SELW'(1);
    end else if (state == FULL && io.out_ready) begin
      state <= IDLE;
      vld_q <= 1'b0;
    end
  end

endmodule
